// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - page/warn encodings, FSM states and alert priority helper
package display_pkg;

  localparam logic [1:0] PAGE_DRIVE = 2'd0;
  localparam logic [1:0] PAGE_OBD   = 2'd1;
  localparam logic [1:0] PAGE_WARN  = 2'd2;

  localparam logic [3:0] WARN_NONE     = 4'd0;
  localparam logic [3:0] WARN_OVERHEAT = 4'd1;
  localparam logic [3:0] WARN_OVERREV  = 4'd2;
  localparam logic [3:0] WARN_LOWFUEL  = 4'd3;

  typedef enum logic {
    ST_USER = 1'b0,
    ST_WARN = 1'b1
  } state_t;

  // Alert index 0=overheat, 1=over-rev, 2=low fuel; lower index wins.
  function automatic logic [1:0] top_alert(input logic [2:0] p);
    if (p[0])      return 2'd0;
    else if (p[1]) return 2'd1;
    else           return 2'd2;
  endfunction

endpackage

// File: rtl/display_page_sched_if.sv
// rtl/display_page_sched_if.sv - vehicle-state inputs and display-unit outputs
interface display_page_sched_if;
  logic        tick_100ms;
  logic        mode_btn;
  logic [13:0] rpm;
  logic [7:0]  fuel;
  logic [7:0]  temp;
  logic [1:0]  page_sel;
  logic [3:0]  warn_code;
  logic        blank;
  logic        page_changed;

  modport master (
    output tick_100ms, mode_btn, rpm, fuel, temp,
    input  page_sel, warn_code, blank, page_changed
  );

  modport slave (
    input  tick_100ms, mode_btn, rpm, fuel, temp,
    output page_sel, warn_code, blank, page_changed
  );
endinterface

// File: rtl/alert_hyst.sv
// rtl/alert_hyst.sv - registered threshold flag with hysteresis and rising-edge output
module alert_hyst #(
  parameter int WIDTH       = 8,
  parameter int SET_TH      = 0,
  parameter int CLR_TH      = 0,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  output logic             flag_next,
  output logic             rise
);

  logic flag;
  logic set_c;
  logic clr_c;

  // ACTIVE_HIGH: alert when value is high; otherwise alert when value is low.
  generate
    if (ACTIVE_HIGH) begin : g_high
      assign set_c = (value >= WIDTH'(SET_TH));
      assign clr_c = (value <  WIDTH'(CLR_TH));
    end else begin : g_low
      assign set_c = (value <  WIDTH'(SET_TH));
      assign clr_c = (value >= WIDTH'(CLR_TH));
    end
  endgenerate

  assign flag_next = flag ? ~clr_c : set_c;
  assign rise      = flag_next & ~flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag <= 1'b0;
    else     flag <= flag_next;
  end

endmodule

// File: rtl/display_page_sched.sv
// rtl/display_page_sched.sv - dashboard page sequencer with prioritised blinking warnings
module display_page_sched
  import display_pkg::*;
#(
  parameter int FUEL_LOW   = 10,
  parameter int FUEL_HYST  = 3,
  parameter int TEMP_HIGH  = 110,
  parameter int TEMP_HYST  = 5,
  parameter int RPM_RED    = 6500,
  parameter int RPM_HYST   = 300,
  parameter int WARN_HOLD  = 30,
  parameter int BLINK_HALF = 5,
  parameter int REMIND     = 300
) (
  input  logic               clk,
  input  logic               rst,
  display_page_sched_if.slave bus
);

  logic [2:0] flag_n;
  logic [2:0] rise;

  alert_hyst #(.WIDTH(8), .SET_TH(TEMP_HIGH), .CLR_TH(TEMP_HIGH - TEMP_HYST), .ACTIVE_HIGH(1'b1))
    u_overheat (.clk(clk), .rst(rst), .value(bus.temp), .flag_next(flag_n[0]), .rise(rise[0]));

  alert_hyst #(.WIDTH(14), .SET_TH(RPM_RED), .CLR_TH(RPM_RED - RPM_HYST), .ACTIVE_HIGH(1'b1))
    u_overrev (.clk(clk), .rst(rst), .value(bus.rpm), .flag_next(flag_n[1]), .rise(rise[1]));

  alert_hyst #(.WIDTH(8), .SET_TH(FUEL_LOW), .CLR_TH(FUEL_LOW + FUEL_HYST), .ACTIVE_HIGH(1'b0))
    u_lowfuel (.clk(clk), .rst(rst), .value(bus.fuel), .flag_next(flag_n[2]), .rise(rise[2]));

  state_t      state_q, state_n;
  logic        user_page_q, user_page_n;
  logic [1:0]  shown_q, shown_n;
  logic [2:0]  pending_q, pending_n;
  logic [2:0]  ack_q, ack_n;
  logic [15:0] warn_timer_q, warn_timer_n;
  logic [15:0] blink_q, blink_n;
  logic [15:0] remind_q, remind_n;
  logic        blank_q, blank_n;
  logic        btn_q;
  logic [1:0]  page_sel_q, page_sel_n;
  logic [3:0]  warn_code_q, warn_code_n;
  logic        page_changed_q, page_changed_n;

  logic       press;
  logic       done;
  logic       exit_warn;
  logic [2:0] active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_USER;
      user_page_q    <= 1'b0;
      shown_q        <= 2'd0;
      pending_q      <= 3'b000;
      ack_q          <= 3'b000;
      warn_timer_q   <= 16'd0;
      blink_q        <= 16'd0;
      remind_q       <= 16'd0;
      blank_q        <= 1'b0;
      btn_q          <= 1'b0;
      page_sel_q     <= PAGE_DRIVE;
      warn_code_q    <= WARN_NONE;
      page_changed_q <= 1'b0;
    end else begin
      state_q        <= state_n;
      user_page_q    <= user_page_n;
      shown_q        <= shown_n;
      pending_q      <= pending_n;
      ack_q          <= ack_n;
      warn_timer_q   <= warn_timer_n;
      blink_q        <= blink_n;
      remind_q       <= remind_n;
      blank_q        <= blank_n;
      btn_q          <= bus.mode_btn;
      page_sel_q     <= page_sel_n;
      warn_code_q    <= warn_code_n;
      page_changed_q <= page_changed_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    user_page_n  = user_page_q;
    shown_n      = shown_q;
    warn_timer_n = warn_timer_q;
    blink_n      = blink_q;
    remind_n     = remind_q;
    blank_n      = blank_q;
    done         = 1'b0;
    exit_warn    = 1'b0;
    press        = bus.mode_btn & ~btn_q;

    // Ack survives only while its alert stays active.
    ack_n     = ack_q & flag_n;
    pending_n = pending_q | (rise & ~ack_n);

    if (state_q == ST_WARN) begin
      done = bus.tick_100ms && (warn_timer_q == 16'(WARN_HOLD - 1));
      if (press) ack_n[shown_q] = flag_n[shown_q];
      if (done || press || !flag_n[shown_q]) begin
        pending_n[shown_q] = 1'b0;
        exit_warn          = 1'b1;
      end
    end else if (press) begin
      user_page_n = ~user_page_q;
    end

    active = flag_n & ~ack_n;
    if (active == 3'b000) begin
      remind_n = 16'd0;
    end else if (bus.tick_100ms) begin
      if (remind_q >= 16'(REMIND - 1)) begin
        remind_n  = 16'd0;
        pending_n = pending_n | active;
      end else begin
        remind_n = remind_q + 16'd1;
      end
    end

    // Showing restarts on entry, after an exit, or on preemption.
    if (pending_n != 3'b000) begin
      state_n = ST_WARN;
      shown_n = top_alert(pending_n);
      if (state_q == ST_USER || exit_warn || shown_n != shown_q) begin
        warn_timer_n = 16'd0;
        blink_n      = 16'd0;
        blank_n      = 1'b0;
      end else if (bus.tick_100ms) begin
        if (warn_timer_q != 16'hffff) warn_timer_n = warn_timer_q + 16'd1;
        if (blink_q >= 16'(BLINK_HALF - 1)) begin
          blink_n = 16'd0;
          blank_n = ~blank_q;
        end else begin
          blink_n = blink_q + 16'd1;
        end
      end
    end else begin
      state_n      = ST_USER;
      warn_timer_n = 16'd0;
      blink_n      = 16'd0;
      blank_n      = 1'b0;
    end

    if (state_n == ST_WARN) begin
      page_sel_n  = PAGE_WARN;
      warn_code_n = {2'b00, shown_n} + 4'd1;
    end else begin
      page_sel_n  = user_page_n ? PAGE_OBD : PAGE_DRIVE;
      warn_code_n = WARN_NONE;
    end
    page_changed_n = (page_sel_n != page_sel_q);
  end

  assign bus.page_sel     = page_sel_q;
  assign bus.warn_code    = warn_code_q;
  assign bus.blank        = blank_q;
  assign bus.page_changed = page_changed_q;

endmodule

// File: tb/tb_display_page_sched.sv
// tb/tb_display_page_sched.sv - directed self-checking bench for display_page_sched
module tb_display_page_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  display_page_sched_if bus();

  display_page_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_100ms = 1'b1;
      step();
      bus.tick_100ms = 1'b0;
      step();
    end
  endtask

  initial begin
    bus.tick_100ms = 1'b0;
    bus.mode_btn   = 1'b0;
    bus.rpm        = 14'd1000;
    bus.fuel       = 8'd20;
    bus.temp       = 8'd80;
    step();
    step();
    chk("rst_page", int'(bus.page_sel), 0);
    chk("rst_code", int'(bus.warn_code), 0);
    chk("rst_blank", int'(bus.blank), 0);
    chk("rst_chg", int'(bus.page_changed), 0);
    rst = 1'b0;
    step();

    // Three presses toggle DRIVE/OBD
    for (int i = 0; i < 3; i++) begin
      bus.mode_btn = 1'b1;
      step();
      chk("press_page", int'(bus.page_sel), (i % 2 == 0) ? 1 : 0);
      chk("press_chg", int'(bus.page_changed), 1);
      bus.mode_btn = 1'b0;
      step();
      chk("release_chg", int'(bus.page_changed), 0);
    end

    // Low fuel warning, blink and timeout back to OBD
    bus.fuel = 8'd9;
    step();
    chk("lf_page", int'(bus.page_sel), 2);
    chk("lf_code", int'(bus.warn_code), 3);
    chk("lf_blank0", int'(bus.blank), 0);
    chk("lf_chg", int'(bus.page_changed), 1);
    tick_n(4);
    chk("lf_blank4", int'(bus.blank), 0);
    tick_n(1);
    chk("lf_blank5", int'(bus.blank), 1);
    tick_n(5);
    chk("lf_blank10", int'(bus.blank), 0);
    tick_n(19);
    chk("lf_hold29", int'(bus.page_sel), 2);
    tick_n(1);
    chk("lf_done_page", int'(bus.page_sel), 1);
    chk("lf_done_code", int'(bus.warn_code), 0);

    // Reminder at 300 ticks after the alert went active
    tick_n(269);
    chk("rem_299", int'(bus.page_sel), 1);
    tick_n(1);
    chk("rem_300_page", int'(bus.page_sel), 2);
    chk("rem_300_code", int'(bus.warn_code), 3);
    bus.mode_btn = 1'b1;
    step();
    chk("ack_page", int'(bus.page_sel), 1);
    chk("ack_code", int'(bus.warn_code), 0);
    bus.mode_btn = 1'b0;
    step();
    tick_n(310);
    chk("ack_no_remind", int'(bus.page_sel), 1);
    bus.fuel = 8'd13;
    step();
    chk("refuel_page", int'(bus.page_sel), 1);
    bus.fuel = 8'd9;
    step();
    chk("relow_page", int'(bus.page_sel), 2);
    chk("relow_code", int'(bus.warn_code), 3);

    // Overheat preempts low fuel, then low fuel shown in full
    tick_n(10);
    bus.temp = 8'd110;
    step();
    chk("oh_code", int'(bus.warn_code), 1);
    chk("oh_blank", int'(bus.blank), 0);
    tick_n(29);
    chk("oh_hold", int'(bus.warn_code), 1);
    tick_n(1);
    chk("lf_resume_code", int'(bus.warn_code), 3);
    chk("lf_resume_page", int'(bus.page_sel), 2);
    tick_n(29);
    chk("lf_resume_hold", int'(bus.warn_code), 3);
    tick_n(1);
    chk("lf_resume_done", int'(bus.page_sel), 1);
    bus.temp = 8'd90;
    bus.fuel = 8'd50;
    step();
    chk("clear_page", int'(bus.page_sel), 1);

    // Over-rev hysteresis
    bus.rpm = 14'd6600;
    step();
    chk("rev_code", int'(bus.warn_code), 2);
    bus.rpm = 14'd6300;
    step();
    chk("rev_hyst_code", int'(bus.warn_code), 2);
    bus.rpm = 14'd6100;
    step();
    chk("rev_clr_page", int'(bus.page_sel), 1);
    chk("rev_clr_code", int'(bus.warn_code), 0);

    // Asynchronous reset mid-WARN
    bus.rpm = 14'd6600;
    step();
    chk("rev2_page", int'(bus.page_sel), 2);
    tick_n(3);
    rst = 1'b1;
    #1;
    chk("arst_page", int'(bus.page_sel), 0);
    chk("arst_code", int'(bus.warn_code), 0);
    chk("arst_blank", int'(bus.blank), 0);
    chk("arst_chg", int'(bus.page_changed), 0);
    bus.rpm = 14'd1000;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_page", int'(bus.page_sel), 0);
    chk("post_rst_code", int'(bus.warn_code), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
